// File: rtl/fetch_stage_if.sv
// fetch_stage_if: control inputs, instruction-memory port and IF/ID outputs of the fetch stage
interface fetch_stage_if #(parameter int ADDR_W = 7);
  logic              stall;
  logic              branch_taken;
  logic [ADDR_W-1:0] branch_target;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_data;
  logic [31:0]       instr_out;
  logic [ADDR_W-1:0] pc_out;
  logic              valid_out;
  logic              done;
  logic [15:0]       fetch_count;
  modport master(input stall, branch_taken, branch_target, imem_data,
                 output imem_addr, instr_out, pc_out, valid_out, done, fetch_count);
  modport slave(output stall, branch_taken, branch_target, imem_data,
                input imem_addr, instr_out, pc_out, valid_out, done, fetch_count);
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: PC, instruction fetch into IF/ID, branch redirect, stall, halt drain and done
module fetch_stage #(
  parameter int          ADDR_W       = 7,
  parameter int          PROG_LEN     = 128,
  parameter logic [4:0]  HALT_OP      = 5'b11111,
  parameter int          DRAIN_CYCLES = 4,
  parameter logic [31:0] NOP          = 32'h0000_0000
) (
  input logic clk,
  input logic rst,
  fetch_stage_if.master bus
);
  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(PROG_LEN - 1);
  localparam logic [ADDR_W:0]   LEN   = (ADDR_W + 1)'(PROG_LEN);
  localparam logic [2:0]        DLAST = 3'(DRAIN_CYCLES - 1);
  state_t            state, state_n;
  logic [ADDR_W-1:0] pc, pc_n, pc_q, pc_q_n;
  logic [2:0]        cnt, cnt_n;
  logic [31:0]       instr, instr_n;
  logic              valid, valid_n, done, done_n, last;
  logic [15:0]       count, count_n;
  assign last = bus.imem_data[31:27] == HALT_OP || pc == LAST;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      pc    <= '0;
      cnt   <= '0;
      instr <= NOP;
      pc_q  <= '0;
      valid <= 1'b0;
      done  <= 1'b0;
      count <= '0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      cnt   <= cnt_n;
      instr <= instr_n;
      pc_q  <= pc_q_n;
      valid <= valid_n;
      done  <= done_n;
      count <= count_n;
    end
  end
  always_comb begin
    state_n = state;
    pc_n    = pc;
    cnt_n   = cnt;
    instr_n = instr;
    pc_q_n  = pc_q;
    valid_n = valid;
    done_n  = done;
    count_n = count;
    if (bus.branch_taken && state != DONE) begin
      // a target outside the program drains instead of fetching garbage
      pc_n    = bus.branch_target;
      instr_n = NOP;
      valid_n = 1'b0;
      cnt_n   = '0;
      state_n = {1'b0, bus.branch_target} >= LEN ? DRAIN : RUN;
    end else if (state == RUN && !bus.stall) begin
      instr_n = bus.imem_data;
      pc_q_n  = pc;
      valid_n = 1'b1;
      count_n = count + 16'(count != 16'hFFFF);
      pc_n    = last ? pc : pc + 1'b1;
      state_n = last ? DRAIN : RUN;
      cnt_n   = '0;
    end else if (state == DRAIN && !bus.stall) begin
      instr_n = NOP;
      valid_n = 1'b0;
      cnt_n   = cnt + 1'b1;
      state_n = cnt == DLAST ? DONE : DRAIN;
      done_n  = cnt == DLAST;
    end
  end
  assign bus.imem_addr   = pc;
  assign bus.instr_out   = instr;
  assign bus.pc_out      = pc_q;
  assign bus.valid_out   = valid;
  assign bus.done        = done;
  assign bus.fetch_count = count;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: table-driven vectors on a 128-word program plus hand sequences on an 8-word program
module tb_fetch_stage;
  typedef struct {
    logic        rst, stall, br;
    logic [6:0]  tgt;
    logic [31:0] instr;
    logic [6:0]  pc;
    logic        valid, done;
    logic [15:0] cnt;
  } vec_t;
  localparam logic [31:0] HALT = 32'hF800_0000;
  logic clk = 1'b0, rst = 1'b1, rst1 = 1'b1;
  int n_cmp = 0, n_fail = 0;
  vec_t tv[$];
  logic [31:0] mem0[128];
  always #5 clk = ~clk;
  fetch_stage_if #(.ADDR_W(7)) b0();
  fetch_stage_if #(.ADDR_W(7)) b1();
  fetch_stage #(.PROG_LEN(128)) u0(.clk(clk), .rst(rst), .bus(b0.master));
  fetch_stage #(.PROG_LEN(8)) u1(.clk(clk), .rst(rst1), .bus(b1.master));
  function automatic logic [31:0] w(int a);
    return 32'h0800_0001 + 32'(a);
  endfunction
  assign b0.imem_data = mem0[b0.imem_addr];
  assign b1.imem_data = w(int'(b1.imem_addr));
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", n, act, exp);
    end
  endtask
  task automatic add(input int r, s, b, t, input logic [31:0] i, input int p, v, d, c);
    tv.push_back('{rst: 1'(r), stall: 1'(s), br: 1'(b), tgt: 7'(t), instr: i,
                   pc: 7'(p), valid: 1'(v), done: 1'(d), cnt: 16'(c)});
  endtask
  initial begin
    for (int a = 0; a < 128; a++) mem0[a] = w(a);
    mem0[6] = HALT;
    {b0.stall, b0.branch_taken, b0.branch_target} = '0;
    {b1.stall, b1.branch_taken, b1.branch_target} = '0;
    add(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int a = 0; a < 6; a++) add(0, 0, 0, 0, w(a), a, 1, 0, a + 1);
    add(0, 0, 0, 0, HALT, 6, 1, 0, 7);
    for (int k = 0; k < 3; k++) add(0, 0, 0, 0, 0, 6, 0, 0, 7);
    add(0, 0, 0, 0, 0, 6, 0, 1, 7);
    add(0, 1, 1, 16, 0, 6, 0, 1, 7);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int a = 0; a < 3; a++) add(0, 0, 0, 0, w(a), a, 1, 0, a + 1);
    add(0, 0, 1, 32, 0, 2, 0, 0, 3);
    add(0, 0, 0, 0, w(32), 32, 1, 0, 4);
    add(0, 0, 0, 0, w(33), 33, 1, 0, 5);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int a = 0; a < 2; a++) add(0, 0, 0, 0, w(a), a, 1, 0, a + 1);
    for (int k = 0; k < 3; k++) add(0, 1, 0, 0, w(1), 1, 1, 0, 2);
    add(0, 1, 1, 48, 0, 1, 0, 0, 2);
    add(0, 0, 0, 0, w(48), 48, 1, 0, 3);
    add(0, 0, 1, 5, 0, 48, 0, 0, 3);
    add(0, 0, 0, 0, w(5), 5, 1, 0, 4);
    add(0, 0, 0, 0, HALT, 6, 1, 0, 5);
    for (int k = 0; k < 2; k++) add(0, 0, 0, 0, 0, 6, 0, 0, 5);
    add(0, 0, 1, 16, 0, 6, 0, 0, 5);
    add(0, 0, 0, 0, w(16), 16, 1, 0, 6);
    add(0, 0, 0, 0, w(17), 17, 1, 0, 7);
    add(0, 0, 1, 6, 0, 17, 0, 0, 7);
    add(0, 0, 0, 0, HALT, 6, 1, 0, 8);
    add(0, 1, 0, 0, HALT, 6, 1, 0, 8);
    for (int k = 0; k < 3; k++) add(0, 0, 0, 0, 0, 6, 0, 0, 8);
    add(0, 0, 0, 0, 0, 6, 0, 1, 8);
    foreach (tv[i]) begin
      rst = tv[i].rst;
      b0.stall = tv[i].stall;
      b0.branch_taken = tv[i].br;
      b0.branch_target = tv[i].tgt;
      tick();
      chk($sformatf("row%0d instr", i), b0.instr_out, tv[i].instr);
      chk($sformatf("row%0d pc_out", i), 32'(b0.pc_out), 32'(tv[i].pc));
      chk($sformatf("row%0d valid", i), 32'(b0.valid_out), 32'(tv[i].valid));
      chk($sformatf("row%0d done", i), 32'(b0.done), 32'(tv[i].done));
      chk($sformatf("row%0d count", i), 32'(b0.fetch_count), 32'(tv[i].cnt));
    end
    rst = 1'b0;
    {b0.stall, b0.branch_taken} = '0;
    tick();
    chk("eop reset done", 32'(b1.done), 0);
    chk("eop reset count", 32'(b1.fetch_count), 0);
    rst1 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk($sformatf("eop instr%0d", k), b1.instr_out, w(k));
      chk($sformatf("eop pc_out%0d", k), 32'(b1.pc_out), 32'(k));
      chk($sformatf("eop valid%0d", k), 32'(b1.valid_out), 1);
    end
    chk("eop pc held", 32'(b1.imem_addr), 7);
    chk("eop count", 32'(b1.fetch_count), 8);
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk($sformatf("eop done+%0d", k), 32'(b1.done), 32'(k == 4));
      chk($sformatf("eop no wrap+%0d", k), 32'(b1.imem_addr), 7);
    end
    chk("eop bubble", b1.instr_out, 0);
    rst1 = 1'b1;
    tick();
    rst1 = 1'b0;
    chk("rst in done: done", 32'(b1.done), 0);
    chk("rst in done: count", 32'(b1.fetch_count), 0);
    chk("rst in done: pc", 32'(b1.imem_addr), 0);
    chk("rst in done: valid", 32'(b1.valid_out), 0);
    tick();
    chk("restart instr", b1.instr_out, w(0));
    chk("restart pc_out", 32'(b1.pc_out), 0);
    tick();
    b1.branch_taken = 1'b1;
    b1.branch_target = 7'd9;
    tick();
    b1.branch_taken = 1'b0;
    chk("oob valid", 32'(b1.valid_out), 0);
    chk("oob instr", b1.instr_out, 0);
    chk("oob pc", 32'(b1.imem_addr), 9);
    chk("oob pc_out", 32'(b1.pc_out), 1);
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk($sformatf("oob done+%0d", k), 32'(b1.done), 32'(k == 4));
      chk($sformatf("oob count+%0d", k), 32'(b1.fetch_count), 2);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
